mascara_filtro_dbuf: RTL and testbench

Parametrised, double-buffered filter-mask loader for the convolution datapath. It fetches a variable number of packed coefficients from physical memory through the `leer`/`lectura_completada` handshake into a shadow bank. The active bank keeps driving the filter with the current mask until a bank swap is requested, so a new kernel can be loaded without stalling filtering. It sits between the memory arbiter and the filter MAC array, replacing the fixed 27-output, single-bank mask loader.

---
 rtl/mascara_filtro_pkg.sv | 24 ++
 rtl/mascara_banco.sv | 59 +++++
 rtl/mascara_filtro_dbuf.sv | 205 ++++++++++++++++++++
 tb/tb_mascara_filtro_dbuf.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mascara_filtro_pkg.sv
// mascara_filtro_pkg
// Shared definitions for the double-buffered filter-mask loader:
//   - estado_t            : loader FSM states (REPOSO, LEER, AVANZAR)
//   - CPW                 : coefficients per memory word for the default
//                           widths (32-bit words, 10-bit coefficients)
//   - palabras_necesarias : number of memory words needed for a tap count
package mascara_filtro_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    LEER    = 2'd1,
    AVANZAR = 2'd2
  } estado_t;

  localparam int COEF_W_DEF = 10;
  localparam int DATA_W_DEF = 32;
  localparam int CPW        = DATA_W_DEF / COEF_W_DEF;

  // Ceil-divide: words to fetch for num_coef taps at cpw taps per word.
  function automatic int palabras_necesarias(input int num_coef, input int cpw = CPW);
    return (num_coef + cpw - 1) / cpw;
  endfunction

endpackage

// File: rtl/mascara_banco.sv
// mascara_banco
// MAX_TAPS x COEF_W coefficient register bank. Used twice by the loader:
// once as the shadow bank (cleared, then filled word by word) and once as
// the active bank (loaded in parallel from the shadow on a swap).
// Ports:
//   clk, reset      : clock, synchronous active-high reset (clears bank)
//   clear_i         : synchronous clear of every tap
//   wr_en_i         : write the CPW taps of wr_data_i at word word_idx_i;
//                     taps at index >= cap_i are left untouched
//   word_idx_i      : word index (taps word_idx_i*CPW .. +CPW-1)
//   cap_i           : tap-count cap for word writes
//   wr_data_i       : CPW packed coefficients, tap k at [k*COEF_W +: COEF_W]
//   load_en_i       : parallel load of the whole bank from load_data_i
//   load_data_i     : full bank image, tap i at [i*COEF_W +: COEF_W]
//   bank_o          : current bank contents, same packing
// Priority: reset/clear > parallel load > word write.
module mascara_banco
  import mascara_filtro_pkg::*;
#(
  parameter int COEF_W   = 10,
  parameter int MAX_TAPS = 27,
  parameter int CPW      = 3,
  parameter int CNT_W    = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic                         wr_en_i,
  input  logic [CNT_W-1:0]             word_idx_i,
  input  logic [CNT_W-1:0]             cap_i,
  input  logic [CPW*COEF_W-1:0]        wr_data_i,
  input  logic                         load_en_i,
  input  logic [MAX_TAPS*COEF_W-1:0]   load_data_i,
  output logic [MAX_TAPS*COEF_W-1:0]   bank_o
);

  logic [COEF_W-1:0] taps_q [MAX_TAPS];

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int i = 0; i < MAX_TAPS; i++) taps_q[i] <= '0;
    end else if (load_en_i) begin
      for (int i = 0; i < MAX_TAPS; i++) taps_q[i] <= load_data_i[i*COEF_W +: COEF_W];
    end else if (wr_en_i) begin
      // Each tap decides for itself whether it belongs to the word being
      // written and lies below the cap; taps past the cap keep their zero.
      for (int i = 0; i < MAX_TAPS; i++) begin
        if (((i / CPW) == int'(word_idx_i)) && (i < int'(cap_i))) begin
          taps_q[i] <= wr_data_i[(i % CPW)*COEF_W +: COEF_W];
        end
      end
    end
  end

  for (genvar g = 0; g < MAX_TAPS; g++) begin : g_out
    assign bank_o[g*COEF_W +: COEF_W] = taps_q[g];
  end

endmodule

// File: rtl/mascara_filtro_dbuf.sv
// mascara_filtro_dbuf
// Double-buffered filter-mask loader. Fetches num_coef packed coefficients
// from memory (leer / lectura_completada handshake) into a shadow bank while
// the active bank keeps driving the filter; a swap copies shadow to active.
// Build option: MASCARA_FILTRO_AUTO_SWAP_EN -- when defined the swap happens
// by itself on the edge after sombra_lista rises and cambiar_banco is unused.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   num_coef                      : taps to load (1..MAX_TAPS legal)
//   direccion_mem_inicio_mascara  : address of the first word
//   iniciar_lectura               : start-load pulse
//   lectura_completada            : memory ack, datos_memoria valid
//   datos_memoria                 : read word, tap k at [k*COEF_W +: COEF_W]
//   cambiar_banco                 : swap request
//   direccion_mem_fisica, leer    : read address / request
//   ocupado                       : load in progress
//   error_tamano                  : one-cycle pulse on illegal num_coef
//   sombra_lista                  : shadow complete, not yet swapped
//   mascara_valida, mascara_nueva : active mask loaded / swap pulse
//   num_coef_activo, coeficientes : active tap count and taps
//   estado_o                      : FSM state for observation
// Handshake: while leer=1 the address is stable; the memory answers with a
// single-cycle lectura_completada carrying the word. Acks outside LEER are
// ignored; after an ack leer drops for one cycle before the next request.
module mascara_filtro_dbuf
  import mascara_filtro_pkg::*;
#(
  parameter int COEF_W   = 10,
  parameter int MAX_TAPS = 27,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [$clog2(MAX_TAPS+1)-1:0]    num_coef,
  input  logic [ADDR_W-1:0]                direccion_mem_inicio_mascara,
  input  logic                             iniciar_lectura,
  input  logic                             lectura_completada,
  input  logic [DATA_W-1:0]                datos_memoria,
  input  logic                             cambiar_banco,
  output logic [ADDR_W-1:0]                direccion_mem_fisica,
  output logic                             leer,
  output logic                             ocupado,
  output logic                             error_tamano,
  output logic                             sombra_lista,
  output logic                             mascara_valida,
  output logic                             mascara_nueva,
  output logic [$clog2(MAX_TAPS+1)-1:0]    num_coef_activo,
  output logic [MAX_TAPS*COEF_W-1:0]       coeficientes,
  output logic [1:0]                       estado_o
);

  localparam int CPW_L  = DATA_W / COEF_W;
  localparam int CNT_W  = $clog2(MAX_TAPS + 1);
  localparam int WORD_W = CPW_L * COEF_W;
  localparam int BANK_W = MAX_TAPS * COEF_W;

  estado_t           state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  num_q, nwords_q, idx_q, idx_d, num_act_q;
  logic              leer_q, ocupado_q, sombra_q, valida_q, nueva_q, error_q;

  logic legal, arranque, swap, ack_leer, ultima;
  logic [BANK_W-1:0] sombra_bank;

  assign legal    = (num_coef != '0) && (int'(num_coef) <= MAX_TAPS);
  assign arranque = (state_q == REPOSO) && iniciar_lectura && legal;
  assign ack_leer = (state_q == LEER) && lectura_completada;
  assign ultima   = (idx_q == nwords_q - 1'b1);
  assign addr_d   = addr_q + 1'b1;
  assign idx_d    = idx_q + 1'b1;

`ifdef MASCARA_FILTRO_AUTO_SWAP_EN
  // sombra_lista is visible for exactly one cycle before the automatic swap.
  assign swap = sombra_q;
  logic unused_cambiar;
  assign unused_cambiar = cambiar_banco;
`else
  assign swap = cambiar_banco && sombra_q;
`endif

  // Words wider than CPW coefficients carry unused upper bits.
  if (DATA_W > WORD_W) begin : g_unused
    logic unused_datos;
    assign unused_datos = ^datos_memoria[DATA_W-1:WORD_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= REPOSO;
      addr_q    <= '0;
      num_q     <= '0;
      nwords_q  <= '0;
      idx_q     <= '0;
      num_act_q <= '0;
      leer_q    <= 1'b0;
      ocupado_q <= 1'b0;
      sombra_q  <= 1'b0;
      valida_q  <= 1'b0;
      nueva_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      nueva_q <= 1'b0;
      error_q <= 1'b0;

      // The swap reads the pending shadow and count before any new load
      // started in the same cycle replaces them.
      if (swap) begin
        num_act_q <= num_q;
        valida_q  <= 1'b1;
        nueva_q   <= 1'b1;
        sombra_q  <= 1'b0;
      end

      case (state_q)
        REPOSO: begin
          if (iniciar_lectura) begin
            if (legal) begin
              addr_q    <= direccion_mem_inicio_mascara;
              num_q     <= num_coef;
              nwords_q  <= CNT_W'(palabras_necesarias(int'(num_coef), CPW_L));
              idx_q     <= '0;
              sombra_q  <= 1'b0;
              leer_q    <= 1'b1;
              ocupado_q <= 1'b1;
              state_q   <= LEER;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        LEER: begin
          if (lectura_completada) begin
            leer_q <= 1'b0;
            if (ultima) begin
              sombra_q  <= 1'b1;
              ocupado_q <= 1'b0;
              state_q   <= REPOSO;
            end else begin
              addr_q  <= addr_d;
              idx_q   <= idx_d;
              state_q <= AVANZAR;
            end
          end
        end
        AVANZAR: begin
          leer_q  <= 1'b1;
          state_q <= LEER;
        end
        default: begin
          leer_q    <= 1'b0;
          ocupado_q <= 1'b0;
          state_q   <= REPOSO;
        end
      endcase
    end
  end

  mascara_banco #(
    .COEF_W  (COEF_W),
    .MAX_TAPS(MAX_TAPS),
    .CPW     (CPW_L),
    .CNT_W   (CNT_W)
  ) u_sombra (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (arranque),
    .wr_en_i    (ack_leer),
    .word_idx_i (idx_q),
    .cap_i      (num_q),
    .wr_data_i  (datos_memoria[WORD_W-1:0]),
    .load_en_i  (1'b0),
    .load_data_i({BANK_W{1'b0}}),
    .bank_o     (sombra_bank)
  );

  mascara_banco #(
    .COEF_W  (COEF_W),
    .MAX_TAPS(MAX_TAPS),
    .CPW     (CPW_L),
    .CNT_W   (CNT_W)
  ) u_activo (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (1'b0),
    .wr_en_i    (1'b0),
    .word_idx_i ({CNT_W{1'b0}}),
    .cap_i      ({CNT_W{1'b0}}),
    .wr_data_i  ({WORD_W{1'b0}}),
    .load_en_i  (swap),
    .load_data_i(sombra_bank),
    .bank_o     (coeficientes)
  );

  assign direccion_mem_fisica = addr_q;
  assign leer                 = leer_q;
  assign ocupado              = ocupado_q;
  assign error_tamano         = error_q;
  assign sombra_lista         = sombra_q;
  assign mascara_valida       = valida_q;
  assign mascara_nueva        = nueva_q;
  assign num_coef_activo      = num_act_q;
  assign estado_o             = state_q;

endmodule

// File: tb/tb_mascara_filtro_dbuf.sv
// tb_mascara_filtro_dbuf
// Directed sequence with randomized memory contents and ack delays for the
// double-buffered mask loader. The bench acts as memory and keeps its own
// picture of the expected active mask, computed straight from the packing
// rule (tap t comes from word t/3, slot t%3).
module tb_mascara_filtro_dbuf;

  localparam int COEF_W   = 10;
  localparam int MAX_TAPS = 27;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int TW       = MAX_TAPS * COEF_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0]        num_coef;
  logic [ADDR_W-1:0] direccion_mem_inicio_mascara;
  logic              iniciar_lectura, lectura_completada, cambiar_banco;
  logic [DATA_W-1:0] datos_memoria;
  logic [ADDR_W-1:0] direccion_mem_fisica;
  logic              leer, ocupado, error_tamano, sombra_lista;
  logic              mascara_valida, mascara_nueva;
  logic [4:0]        num_coef_activo;
  logic [TW-1:0]     coeficientes;
  logic [1:0]        estado;

  mascara_filtro_dbuf #(
    .COEF_W(COEF_W), .MAX_TAPS(MAX_TAPS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .num_coef                    (num_coef),
    .direccion_mem_inicio_mascara(direccion_mem_inicio_mascara),
    .iniciar_lectura             (iniciar_lectura),
    .lectura_completada          (lectura_completada),
    .datos_memoria               (datos_memoria),
    .cambiar_banco               (cambiar_banco),
    .direccion_mem_fisica        (direccion_mem_fisica),
    .leer                        (leer),
    .ocupado                     (ocupado),
    .error_tamano                (error_tamano),
    .sombra_lista                (sombra_lista),
    .mascara_valida              (mascara_valida),
    .mascara_nueva               (mascara_nueva),
    .num_coef_activo             (num_coef_activo),
    .coeficientes                (coeficientes),
    .estado_o                    (estado)
  );

  // ---------------- reference model state ----------------
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [TW-1:0]     exp_active;
  int                n_checks = 0;
  int                n_fail   = 0;

  function automatic logic [TW-1:0] exp_mask(input logic [ADDR_W-1:0] start, input int n);
    logic [TW-1:0] r = '0;
    for (int t = 0; t < n; t++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] wd;
      a  = start + ADDR_W'(t / 3);
      wd = mem[a];
      r[t*COEF_W +: COEF_W] = wd[(t % 3)*COEF_W +: COEF_W];
    end
    return r;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_load(input logic [ADDR_W-1:0] start, input logic [4:0] n);
    num_coef = n;
    direccion_mem_inicio_mascara = start;
    iniciar_lectura = 1'b1;
    tick();
    iniciar_lectura = 1'b0;
  endtask

  // Memory side: answer nwords requests, checking address order and that
  // the active mask does not move while the shadow is being filled.
  task automatic serve_words(input logic [ADDR_W-1:0] start, input int nwords,
                             input int delay, input logic [TW-1:0] hold);
    for (int w = 0; w < nwords; w++) begin
      int guard = 0;
      logic [ADDR_W-1:0] ea;
      ea = start + ADDR_W'(w);
      while (leer !== 1'b1 && guard < 50) begin
        tick();
        guard++;
      end
      chk("leer_seen", TW'(leer), TW'(1'b1));
      chk("addr", TW'(direccion_mem_fisica), TW'(ea));
      chk("coef_hold", coeficientes, hold);
      repeat (delay) tick();
      chk("addr_stable", TW'(direccion_mem_fisica), TW'(ea));
      lectura_completada = 1'b1;
      datos_memoria = mem[ea];
      tick();
      lectura_completada = 1'b0;
      datos_memoria = $urandom;
      chk("leer_drop", TW'(leer), TW'(1'b0));
    end
    chk("sombra_set", TW'(sombra_lista), TW'(1'b1));
    chk("ocupado_end", TW'(ocupado), TW'(1'b0));
  endtask

  task automatic do_swap(input logic [TW-1:0] m, input logic [4:0] n);
    cambiar_banco = 1'b1;
    tick();
    cambiar_banco = 1'b0;
    chk("swap_nueva", TW'(mascara_nueva), TW'(1'b1));
    chk("swap_valida", TW'(mascara_valida), TW'(1'b1));
    chk("swap_num", TW'(num_coef_activo), TW'(n));
    chk("swap_coef", coeficientes, m);
    chk("swap_sombra", TW'(sombra_lista), TW'(1'b0));
    exp_active = m;
    tick();
    chk("nueva_pulse", TW'(mascara_nueva), TW'(1'b0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] st;
    logic [4:0]        n;
    logic [TW-1:0]     m;

    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
    exp_active = '0;
    reset = 1'b1;
    num_coef = '0;
    direccion_mem_inicio_mascara = '0;
    iniciar_lectura = 1'b0;
    lectura_completada = 1'b0;
    cambiar_banco = 1'b0;
    datos_memoria = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    chk("rst_leer", TW'(leer), '0);
    chk("rst_ocupado", TW'(ocupado), '0);
    chk("rst_addr", TW'(direccion_mem_fisica), '0);
    chk("rst_sombra", TW'(sombra_lista), '0);
    chk("rst_valida", TW'(mascara_valida), '0);
    chk("rst_nueva", TW'(mascara_nueva), '0);
    chk("rst_error", TW'(error_tamano), '0);
    chk("rst_num", TW'(num_coef_activo), '0);
    chk("rst_coef", coeficientes, '0);

`ifdef MASCARA_FILTRO_AUTO_SWAP_EN
    // Automatic swap: 3 taps in a single word, cambiar_banco held low.
    start_load(10'd5, 5'd3);
    serve_words(10'd5, 1, 0, '0);
    chk("auto_no_yet", TW'(mascara_nueva), '0);
    tick();
    chk("auto_nueva", TW'(mascara_nueva), TW'(1'b1));
    chk("auto_coef", coeficientes, exp_mask(10'd5, 3));
    chk("auto_num", TW'(num_coef_activo), TW'(5'd3));
    chk("auto_sombra", TW'(sombra_lista), '0);
`else
    // Illegal sizes: 28 and 0
    for (int k = 0; k < 2; k++) begin
      num_coef = (k == 0) ? 5'd28 : 5'd0;
      iniciar_lectura = 1'b1;
      tick();
      iniciar_lectura = 1'b0;
      chk("err_pulse", TW'(error_tamano), TW'(1'b1));
      chk("err_leer", TW'(leer), '0);
      chk("err_ocupado", TW'(ocupado), '0);
      chk("err_coef", coeficientes, '0);
      tick();
      chk("err_clear", TW'(error_tamano), '0);
      chk("err_sombra", TW'(sombra_lista), '0);
    end

    // 9 taps from address 2, all-ones words, ack 4 cycles after leer
    for (int i = 2; i <= 4; i++) mem[i] = 32'h3FFF_FFFF;
    start_load(10'd2, 5'd9);
    chk("t1_ocupado", TW'(ocupado), TW'(1'b1));
    serve_words(10'd2, 3, 4, '0);
    chk("t1_valida_pre", TW'(mascara_valida), '0);
    chk("t1_coef_pre", coeficientes, '0);
    do_swap({{(TW-90){1'b0}}, {90{1'b1}}}, 5'd9);
    // Swap request with nothing pending is ignored
    cambiar_banco = 1'b1;
    tick();
    cambiar_banco = 1'b0;
    chk("swap_ign_nueva", TW'(mascara_nueva), '0);
    chk("swap_ign_coef", coeficientes, exp_active);
    for (int i = 2; i <= 4; i++) mem[i] = $urandom;

    // 27 taps across the address wrap
    start_load(10'h3FE, 5'd27);
    serve_words(10'h3FE, 9, 1, exp_active);
    chk("wrap_hold", coeficientes, exp_active);
    do_swap(exp_mask(10'h3FE, 27), 5'd27);

    // Random sizes, addresses and ack delays
    for (int r = 0; r < 4; r++) begin
      n  = 5'($urandom_range(1, MAX_TAPS));
      st = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      start_load(st, n);
      serve_words(st, (int'(n) + 2) / 3, $urandom_range(0, 3), exp_active);
      do_swap(exp_mask(st, int'(n)), n);
    end

    // Swap and new load in the same cycle, then an ignored start in LEER
    st = 10'h155;
    n  = 5'd13;
    start_load(st, n);
    serve_words(st, 5, 0, exp_active);
    m = exp_mask(st, 13);
    cambiar_banco = 1'b1;
    iniciar_lectura = 1'b1;
    num_coef = 5'd6;
    direccion_mem_inicio_mascara = 10'h2A0;
    tick();
    cambiar_banco = 1'b0;
    iniciar_lectura = 1'b0;
    chk("both_nueva", TW'(mascara_nueva), TW'(1'b1));
    chk("both_coef", coeficientes, m);
    chk("both_num", TW'(num_coef_activo), TW'(5'd13));
    chk("both_sombra", TW'(sombra_lista), '0);
    chk("both_ocupado", TW'(ocupado), TW'(1'b1));
    exp_active = m;
    iniciar_lectura = 1'b1;
    num_coef = 5'd28;
    direccion_mem_inicio_mascara = 10'h000;
    tick();
    iniciar_lectura = 1'b0;
    chk("busy_no_err", TW'(error_tamano), '0);
    chk("busy_addr", TW'(direccion_mem_fisica), TW'(10'h2A0));
    serve_words(10'h2A0, 2, 1, exp_active);
    do_swap(exp_mask(10'h2A0, 6), 5'd6);

    // Reset during the second LEER of a 3-word load
    start_load(10'h100, 5'd9);
    lectura_completada = 1'b1;
    datos_memoria = mem[10'h100];
    tick();
    lectura_completada = 1'b0;
    tick();
    chk("mid_leer", TW'(leer), TW'(1'b1));
    chk("mid_addr", TW'(direccion_mem_fisica), TW'(10'h101));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_leer", TW'(leer), '0);
    chk("abort_ocupado", TW'(ocupado), '0);
    chk("abort_coef", coeficientes, '0);
    chk("abort_valida", TW'(mascara_valida), '0);
    cambiar_banco = 1'b1;
    tick();
    cambiar_banco = 1'b0;
    chk("abort_swap_nueva", TW'(mascara_nueva), '0);
    chk("abort_swap_coef", coeficientes, '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
